// File: rtl/game_pkg.sv
// Key codes, PS/2 scan codes and FSM state types shared by the keyboard
// decoder and the game state_machine.
package game_pkg;

   localparam logic [1:0] K_NONE     = 2'b00;
   localparam logic [1:0] K_LEFT     = 2'b01;
   localparam logic [1:0] K_RIGHT    = 2'b10;
   localparam logic [1:0] K_SPACEBAR = 2'b11;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_SPACE = 8'h29;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_EXT,
      DEC_BRK,
      DEC_EXT_BRK
   } dec_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge sampling, framing checks and
// timeout. byte_valid/err pulse one cycle after the stop edge; no backpressure.
module ps2_rx #(
   parameter int TIMEOUT_CYCLES = 65000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data_byte,
   output logic       byte_valid,
   output logic       err
);
   import game_pkg::*;

   localparam int            TW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sh;
   logic [SYNC_STAGES-1:0] dat_sh;
   logic                   sync_prev;
   logic                   sync_cur;
   logic                   sdat;
   logic                   fall;

   rx_state_t   state;
   rx_state_t   state_nxt;
   logic [2:0]  bit_cnt;
   logic        par_acc;
   logic [7:0]  shreg;
   logic [TW-1:0] tmo_cnt;
   logic        valid_nxt;
   logic        err_nxt;

   assign sync_cur  = clk_sh[SYNC_STAGES-1];
   assign sdat      = dat_sh[SYNC_STAGES-1];
   assign fall      = sync_prev & ~sync_cur;
   assign data_byte = shreg;

   always_comb begin
      state_nxt = state;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      if (fall) begin
         case (state)
            RX_IDLE:   if (!sdat) state_nxt = RX_DATA;
            RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
            RX_PARITY: state_nxt = RX_STOP;
            RX_STOP: begin
               state_nxt = RX_IDLE;
               // par_acc holds XOR of data and parity bits; odd parity means 1
               if (sdat && par_acc) valid_nxt = 1'b1;
               else                 err_nxt   = 1'b1;
            end
            default:   state_nxt = RX_IDLE;
         endcase
      end else if (state != RX_IDLE && tmo_cnt == TMO_LAST) begin
         state_nxt = RX_IDLE;
         err_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sh     <= '1;
         dat_sh     <= '1;
         sync_prev  <= 1'b1;
         state      <= RX_IDLE;
         bit_cnt    <= '0;
         par_acc    <= 1'b0;
         shreg      <= '0;
         tmo_cnt    <= '0;
         byte_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         clk_sh     <= {clk_sh[SYNC_STAGES-2:0], ps2_clk};
         dat_sh     <= {dat_sh[SYNC_STAGES-2:0], ps2_data};
         sync_prev  <= sync_cur;
         state      <= state_nxt;
         byte_valid <= valid_nxt;
         err        <= err_nxt;
         tmo_cnt    <= (state == RX_IDLE || fall) ? '0 : tmo_cnt + TW'(1);
         if (fall) begin
            case (state)
               RX_IDLE: begin
                  bit_cnt <= '0;
                  par_acc <= 1'b0;
               end
               RX_DATA: begin
                  shreg   <= {sdat, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  par_acc <= par_acc ^ sdat;
               end
               RX_PARITY: par_acc <= par_acc ^ sdat;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard to 2-bit game key code: one-cycle pulse per fresh key press,
// 2 clk after the synchronised stop edge; no backpressure.
module keyboard_decoder #(
   parameter int TIMEOUT_CYCLES = 65000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [1:0] key,
   output logic       frame_err
);
   import game_pkg::*;

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;

   dec_state_t dec_state;
   dec_state_t dec_nxt;
   logic       held_left;
   logic       held_right;
   logic       held_space;
   logic       held_left_nxt;
   logic       held_right_nxt;
   logic       held_space_nxt;
   logic [1:0] key_nxt;

   ps2_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .data_byte  (rx_byte),
      .byte_valid (rx_valid),
      .err        (rx_err)
   );

   // rx_err is already a registered one-cycle pulse
   assign frame_err = rx_err;

   always_comb begin
      dec_nxt        = dec_state;
      key_nxt        = K_NONE;
      held_left_nxt  = held_left;
      held_right_nxt = held_right;
      held_space_nxt = held_space;
      if (rx_err) begin
         dec_nxt = DEC_IDLE;
      end else if (rx_valid) begin
         dec_nxt = DEC_IDLE;
         case (dec_state)
            DEC_IDLE: begin
               if (rx_byte == SC_EXT)      dec_nxt = DEC_EXT;
               else if (rx_byte == SC_BRK) dec_nxt = DEC_BRK;
               else if (rx_byte == SC_SPACE && !held_space) begin
                  held_space_nxt = 1'b1;
                  key_nxt        = K_SPACEBAR;
               end
            end
            DEC_EXT: begin
               if (rx_byte == SC_BRK)      dec_nxt = DEC_EXT_BRK;
               else if (rx_byte == SC_EXT) dec_nxt = DEC_EXT;
               else if (rx_byte == SC_LEFT && !held_left) begin
                  held_left_nxt = 1'b1;
                  key_nxt       = K_LEFT;
               end else if (rx_byte == SC_RIGHT && !held_right) begin
                  held_right_nxt = 1'b1;
                  key_nxt        = K_RIGHT;
               end
            end
            DEC_BRK: begin
               if (rx_byte == SC_SPACE) held_space_nxt = 1'b0;
            end
            DEC_EXT_BRK: begin
               if (rx_byte == SC_LEFT)       held_left_nxt  = 1'b0;
               else if (rx_byte == SC_RIGHT) held_right_nxt = 1'b0;
            end
            default: dec_nxt = DEC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_state  <= DEC_IDLE;
         key        <= K_NONE;
         held_left  <= 1'b0;
         held_right <= 1'b0;
         held_space <= 1'b0;
      end else begin
         dec_state  <= dec_nxt;
         key        <= key_nxt;
         held_left  <= held_left_nxt;
         held_right <= held_right_nxt;
         held_space <= held_space_nxt;
      end
   end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Directed bench for keyboard_decoder: PS/2 frames driven bit by bit, key and
// frame_err pulses counted by a negedge monitor and compared with hand-derived values.
module tb_keyboard_decoder;

   localparam int HALF = 20;     // ps2 half bit period in clk cycles
   localparam int TMO  = 2000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [1:0] key;
   logic       frame_err;

   int n_chk  = 0;
   int n_fail = 0;

   int cnt_left = 0, cnt_right = 0, cnt_space = 0, cnt_err = 0, cnt_b2b = 0;
   logic [1:0] prev_key = 2'b00;
   logic [1:0] trace [1:6];

   int s_left, s_right, s_space, s_err;

   keyboard_decoder #(
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key       (key),
      .frame_err (frame_err)
   );

   always #8 clk = ~clk;

   always @(negedge clk) begin
      if (key == 2'b01) cnt_left++;
      if (key == 2'b10) cnt_right++;
      if (key == 2'b11) cnt_space++;
      if (frame_err) cnt_err++;
      if (key != 2'b00 && prev_key != 2'b00) cnt_b2b++;
      prev_key = key;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sends bits[0..n-1]; key is traced on the 6 negedges after each falling edge
   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            trace[j] = key;
         end
         repeat (HALF - 6) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
      logic par;
      par = (~^b) ^ bad_par;
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic bad_par);
      send_bits(frame(b, bad_par), 11);
      repeat (40) @(negedge clk);
   endtask

   task automatic snap();
      s_left  = cnt_left;
      s_right = cnt_right;
      s_space = cnt_space;
      s_err   = cnt_err;
   endtask

   initial begin
      repeat (4) @(negedge clk);
      chk("reset_key", 32'(key), 32'h0);
      chk("reset_err", 32'(frame_err), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 1: space make, exact pulse timing
      snap();
      send_byte(8'h29, 1'b0);
      chk("t1_key_n3", 32'(trace[3]), 32'h0);
      chk("t1_key_n4", 32'(trace[4]), 32'h3);
      chk("t1_key_n5", 32'(trace[5]), 32'h0);
      chk("t1_space_cnt", 32'(cnt_space - s_space), 32'd1);
      chk("t1_err_cnt", 32'(cnt_err - s_err), 32'd0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);

      // 2: left press, typematic repeat, release, press again
      snap();
      send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
      send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
      send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h6B, 1'b0);
      send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
      chk("t2_left_cnt", 32'(cnt_left - s_left), 32'd2);
      chk("t2_right_cnt", 32'(cnt_right - s_right), 32'd0);
      chk("t2_space_cnt", 32'(cnt_space - s_space), 32'd0);
      chk("t2_err_cnt", 32'(cnt_err - s_err), 32'd0);

      // 3: bad parity frame, then right make
      snap();
      send_byte(8'h74, 1'b1);
      chk("t3_err_cnt", 32'(cnt_err - s_err), 32'd1);
      chk("t3_no_key", 32'(cnt_right - s_right), 32'd0);
      send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
      chk("t3_right_cnt", 32'(cnt_right - s_right), 32'd1);
      chk("t3_err_total", 32'(cnt_err - s_err), 32'd1);

      // 4: truncated frame then idle line -> timeout
      snap();
      send_bits(frame(8'h29, 1'b0), 5);
      repeat (TMO + 200) @(negedge clk);
      chk("t4_timeout_err", 32'(cnt_err - s_err), 32'd1);
      chk("t4_no_key", 32'(cnt_space - s_space), 32'd0);
      send_byte(8'h29, 1'b0);
      chk("t4_space_after", 32'(cnt_space - s_space), 32'd1);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);

      // 5: reset in the middle of an E0 frame, then 6B alone
      snap();
      send_bits(frame(8'hE0, 1'b0), 6);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_key_in_rst", 32'(key), 32'h0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      send_byte(8'h6B, 1'b0);
      chk("t5_left_cnt", 32'(cnt_left - s_left), 32'd0);
      chk("t5_err_cnt", 32'(cnt_err - s_err), 32'd0);

      // 6: space hold, release, press again; then unknown code
      snap();
      send_byte(8'h29, 1'b0); send_byte(8'h29, 1'b0);
      send_byte(8'hF0, 1'b0); send_byte(8'h29, 1'b0);
      send_byte(8'h29, 1'b0);
      chk("t6_space_cnt", 32'(cnt_space - s_space), 32'd2);
      snap();
      send_byte(8'h1C, 1'b0);
      chk("t6_unknown", 32'((cnt_left - s_left) + (cnt_right - s_right) + (cnt_space - s_space)), 32'd0);
      chk("t6_err_cnt", 32'(cnt_err - s_err), 32'd0);
      chk("no_back_to_back", 32'(cnt_b2b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
